// File: rtl/pipeline_pkg.sv
// Shared decode definitions for the MIPS pipeline ID stage.
// Contents: opcode/funct constants, the interrupt vector default, a compact
// decode record and the function that builds it from opcode and funct.
package pipeline_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BLTZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [31:0] IRQ_VECTOR_DEFAULT = 32'h8000_0004;
    localparam int unsigned LINK_REG_JAL       = 31;

    typedef struct packed {
        logic is_branch;  // conditional branch resolved in ID
        logic is_jump;    // j / jal
        logic is_jal;
        logic is_jr;      // jr / jalr
        logic uses_rs;
        logic uses_rt;
        logic br_rt;      // branch compares rt as well as rs (beq/bne)
    } id_dec_t;

    function automatic id_dec_t id_decode(input logic [5:0] op, input logic [5:0] funct);
        id_dec_t d;
        d           = '0;
        d.is_branch = op inside {OP_BLTZ, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
        d.is_jump   = (op == OP_J) || (op == OP_JAL);
        d.is_jal    = (op == OP_JAL);
        d.is_jr     = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
        d.uses_rs   = !d.is_jump;
        // rt is a source for R-type, beq/bne and stores; elsewhere it is the destination.
        d.uses_rt   = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
                      (op[5:3] == 3'b101);
        d.br_rt     = (op == OP_BEQ) || (op == OP_BNE);
        return d;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file for the ID stage: two combinational read ports, one write port.
// r0 always reads zero and ignores writes. A read of the address being written
// in the same cycle returns the write data (write-through).
// Ports: clk_i, rst_ni (async active-low, clears all registers), we_i/waddr_i/
// wdata_i (write port), raddr_a_i/raddr_b_i -> rdata_a_o/rdata_b_o (read ports).
module id_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int unsigned NumRegs = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [DATA_W-1:0] regs_d [NumRegs];
    logic              wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        if (raddr_a_i == '0) begin
            rdata_a_o = '0;
        end else if (wr_en && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end
        rdata_b_o = regs_q[raddr_b_i];
        if (raddr_b_i == '0) begin
            rdata_b_o = '0;
        end else if (wr_en && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end
    end

endmodule

// File: rtl/pipeline_id_stage.sv
// Decode stage of the 5-stage MIPS pipeline. Owns the IF/ID register, the
// register file, the ID/EX register and the hazard unit. Branches, jumps and
// jr/jalr resolve here using MEM-stage forwarding; interrupts are latched on a
// rising edge of irq and entered by replacing the ID instruction.
// Ports: clk/reset (async active-low); if_* (instruction from IF); id_ready
// (0 = IF must hold); ex_*/mem_* (downstream destinations for hazards and
// forwarding); wb_* (register write port); irq/irq_ack (interrupt request and
// one-cycle acknowledge); redirect_valid/redirect_pc (combinational IF
// redirect); idex_* (ID/EX pipeline register outputs).
module pipeline_id_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       REG_AW       = 5,
    parameter logic [DATA_W-1:0] IRQ_VECTOR   = IRQ_VECTOR_DEFAULT,
    parameter int unsigned       IRQ_LINK_REG = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [31:0]       if_instr,
    output logic              id_ready,
    input  logic              ex_regwr,
    input  logic              ex_memrd,
    input  logic [REG_AW-1:0] ex_wr_reg,
    input  logic              mem_regwr,
    input  logic              mem_memrd,
    input  logic [REG_AW-1:0] mem_wr_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_regwr,
    input  logic [REG_AW-1:0] wb_wr_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              irq,
    output logic              irq_ack,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic              idex_valid,
    output logic              idex_irq,
    output logic [DATA_W-1:0] idex_pc,
    output logic [DATA_W-1:0] idex_rs_data,
    output logic [DATA_W-1:0] idex_rt_data,
    output logic [DATA_W-1:0] idex_imm,
    output logic [31:0]       idex_instr,
    output logic [REG_AW-1:0] idex_wr_reg
);

    // IF/ID register
    logic              ifid_valid_q, ifid_valid_d;
    logic [DATA_W-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;

    // ID/EX register
    logic              idex_valid_q, idex_valid_d;
    logic              idex_irq_q, idex_irq_d;
    logic [DATA_W-1:0] idex_pc_q, idex_pc_d;
    logic [DATA_W-1:0] idex_rs_data_q, idex_rs_data_d;
    logic [DATA_W-1:0] idex_rt_data_q, idex_rt_data_d;
    logic [DATA_W-1:0] idex_imm_q, idex_imm_d;
    logic [31:0]       idex_instr_q, idex_instr_d;
    logic [REG_AW-1:0] idex_wr_reg_q, idex_wr_reg_d;

    // Interrupt state
    logic irq_q, irq_d;
    logic irq_pending_q, irq_pending_d;
    logic irq_ack_q, irq_ack_d;

    // Decode fields
    logic [5:0]        op, funct;
    logic [15:0]       imm16;
    logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr;
    id_dec_t           dec;

    assign op      = ifid_instr_q[31:26];
    assign funct   = ifid_instr_q[5:0];
    assign imm16   = ifid_instr_q[15:0];
    assign rs_addr = REG_AW'(ifid_instr_q[25:21]);
    assign rt_addr = REG_AW'(ifid_instr_q[20:16]);
    assign rd_addr = REG_AW'(ifid_instr_q[15:11]);
    assign dec     = id_decode(op, funct);

    logic [DATA_W-1:0] rf_rs_data, rf_rt_data;

    id_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk_i     (clk),
        .rst_ni    (reset),
        .we_i      (wb_regwr),
        .waddr_i   (wb_wr_reg),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_addr),
        .raddr_b_i (rt_addr),
        .rdata_a_o (rf_rs_data),
        .rdata_b_o (rf_rt_data)
    );

    // Hazard detection and forwarding
    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, mem_fwd_ok;
    logic load_use, ctrl_src, ctrl_ex, ctrl_mem, stall;
    logic [DATA_W-1:0] rs_val, rt_val;

    assign ex_hit_rs  = (ex_wr_reg != '0) && (ex_wr_reg == rs_addr);
    assign ex_hit_rt  = (ex_wr_reg != '0) && (ex_wr_reg == rt_addr);
    assign mem_hit_rs = (mem_wr_reg != '0) && (mem_wr_reg == rs_addr);
    assign mem_hit_rt = (mem_wr_reg != '0) && (mem_wr_reg == rt_addr);
    // Loads in MEM have no data yet, so only ALU results are forwarded.
    assign mem_fwd_ok = mem_regwr && !mem_memrd;

    assign rs_val = (mem_fwd_ok && mem_hit_rs) ? mem_data : rf_rs_data;
    assign rt_val = (mem_fwd_ok && mem_hit_rt) ? mem_data : rf_rt_data;

    assign load_use = ex_memrd && ex_regwr &&
                      ((dec.uses_rs && ex_hit_rs) || (dec.uses_rt && ex_hit_rt));
    assign ctrl_src = dec.is_branch || dec.is_jr;
    // Control transfers compare in ID, so any producer still in EX (or a load in MEM) must wait.
    assign ctrl_ex  = ctrl_src && ex_regwr && (ex_hit_rs || (dec.br_rt && ex_hit_rt));
    assign ctrl_mem = ctrl_src && mem_memrd && mem_regwr &&
                      (mem_hit_rs || (dec.br_rt && mem_hit_rt));
    assign stall    = ifid_valid_q && (load_use || ctrl_ex || ctrl_mem);

    // Branch resolution and targets
    logic              br_taken, ctrl_taken, irq_take;
    logic [DATA_W-1:0] pc_plus4, br_target, j_target, sext_imm;

    assign pc_plus4  = ifid_pc_q + DATA_W'(4);
    assign sext_imm  = {{(DATA_W-16){imm16[15]}}, imm16};
    assign br_target = pc_plus4 + {{(DATA_W-18){imm16[15]}}, imm16, 2'b00};
    assign j_target  = {pc_plus4[DATA_W-1:28], ifid_instr_q[25:0], 2'b00};

    always_comb begin
        br_taken = 1'b0;
        case (op)
            OP_BLTZ: br_taken = rs_val[DATA_W-1];
            OP_BEQ:  br_taken = (rs_val == rt_val);
            OP_BNE:  br_taken = (rs_val != rt_val);
            OP_BLEZ: br_taken = rs_val[DATA_W-1] || (rs_val == '0);
            OP_BGTZ: br_taken = !rs_val[DATA_W-1] && (rs_val != '0);
            default: br_taken = 1'b0;
        endcase
    end

    assign ctrl_taken = ifid_valid_q && !stall &&
                        (dec.is_jump || dec.is_jr || (dec.is_branch && br_taken));
    // Kernel-space code (pc bit 31 set) is never interrupted.
    assign irq_take   = irq_pending_q && ifid_valid_q && !stall && !ifid_pc_q[DATA_W-1];

    always_comb begin
        redirect_valid = irq_take || ctrl_taken;
        if (irq_take) begin
            redirect_pc = IRQ_VECTOR;
        end else if (dec.is_jr) begin
            redirect_pc = rs_val;
        end else if (dec.is_jump) begin
            redirect_pc = j_target;
        end else begin
            redirect_pc = br_target;
        end
    end

    assign id_ready = !stall;

    // Next-state logic
    always_comb begin
        // IF/ID
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (!stall) begin
            if (redirect_valid) begin
                ifid_valid_d = 1'b0;
                ifid_pc_d    = '0;
                ifid_instr_d = '0;
            end else begin
                ifid_valid_d = if_valid;
                ifid_pc_d    = if_pc;
                ifid_instr_d = if_valid ? if_instr : 32'h0;
            end
        end

        // ID/EX
        idex_valid_d   = 1'b0;
        idex_irq_d     = 1'b0;
        idex_pc_d      = '0;
        idex_rs_data_d = '0;
        idex_rt_data_d = '0;
        idex_imm_d     = '0;
        idex_instr_d   = '0;
        idex_wr_reg_d  = '0;
        if (irq_take) begin
            // The ID instruction is dropped and re-executed after return.
            idex_valid_d  = 1'b1;
            idex_irq_d    = 1'b1;
            idex_pc_d     = ifid_pc_q;
            idex_wr_reg_d = REG_AW'(IRQ_LINK_REG);
        end else if (!stall) begin
            idex_valid_d   = ifid_valid_q;
            idex_pc_d      = ifid_pc_q;
            idex_rs_data_d = rs_val;
            idex_rt_data_d = rt_val;
            idex_imm_d     = sext_imm;
            idex_instr_d   = ifid_instr_q;
            if (op == OP_RTYPE) begin
                idex_wr_reg_d = rd_addr;
            end else if (dec.is_jal) begin
                idex_wr_reg_d = REG_AW'(LINK_REG_JAL);
            end else begin
                idex_wr_reg_d = rt_addr;
            end
        end

        // Interrupt latch: a fresh edge in the ack cycle keeps the request pending.
        irq_d         = irq;
        irq_pending_d = (irq && !irq_q) || (irq_pending_q && !irq_take);
        irq_ack_d     = irq_take;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_valid_q   <= 1'b0;
            ifid_pc_q      <= '0;
            ifid_instr_q   <= '0;
            idex_valid_q   <= 1'b0;
            idex_irq_q     <= 1'b0;
            idex_pc_q      <= '0;
            idex_rs_data_q <= '0;
            idex_rt_data_q <= '0;
            idex_imm_q     <= '0;
            idex_instr_q   <= '0;
            idex_wr_reg_q  <= '0;
            irq_q          <= 1'b0;
            irq_pending_q  <= 1'b0;
            irq_ack_q      <= 1'b0;
        end else begin
            ifid_valid_q   <= ifid_valid_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_instr_q   <= ifid_instr_d;
            idex_valid_q   <= idex_valid_d;
            idex_irq_q     <= idex_irq_d;
            idex_pc_q      <= idex_pc_d;
            idex_rs_data_q <= idex_rs_data_d;
            idex_rt_data_q <= idex_rt_data_d;
            idex_imm_q     <= idex_imm_d;
            idex_instr_q   <= idex_instr_d;
            idex_wr_reg_q  <= idex_wr_reg_d;
            irq_q          <= irq_d;
            irq_pending_q  <= irq_pending_d;
            irq_ack_q      <= irq_ack_d;
        end
    end

    assign irq_ack      = irq_ack_q;
    assign idex_valid   = idex_valid_q;
    assign idex_irq     = idex_irq_q;
    assign idex_pc      = idex_pc_q;
    assign idex_rs_data = idex_rs_data_q;
    assign idex_rt_data = idex_rt_data_q;
    assign idex_imm     = idex_imm_q;
    assign idex_instr   = idex_instr_q;
    assign idex_wr_reg  = idex_wr_reg_q;

endmodule

// File: tb/tb_pipeline_id_stage.sv
// Directed bench for pipeline_id_stage: reset, write-through RF, load-use
// stall, branch/jump redirect, MEM forwarding into branches, interrupt entry
// and asynchronous reset during a stall.
module tb_pipeline_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;
    logic        id_ready;
    logic        ex_regwr, ex_memrd;
    logic [4:0]  ex_wr_reg;
    logic        mem_regwr, mem_memrd;
    logic [4:0]  mem_wr_reg;
    logic [31:0] mem_data;
    logic        wb_regwr;
    logic [4:0]  wb_wr_reg;
    logic [31:0] wb_data;
    logic        irq, irq_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        idex_valid, idex_irq;
    logic [31:0] idex_pc, idex_rs_data, idex_rt_data, idex_imm, idex_instr;
    logic [4:0]  idex_wr_reg;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready),
        .ex_regwr       (ex_regwr),
        .ex_memrd       (ex_memrd),
        .ex_wr_reg      (ex_wr_reg),
        .mem_regwr      (mem_regwr),
        .mem_memrd      (mem_memrd),
        .mem_wr_reg     (mem_wr_reg),
        .mem_data       (mem_data),
        .wb_regwr       (wb_regwr),
        .wb_wr_reg      (wb_wr_reg),
        .wb_data        (wb_data),
        .irq            (irq),
        .irq_ack        (irq_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .idex_valid     (idex_valid),
        .idex_irq       (idex_irq),
        .idex_pc        (idex_pc),
        .idex_rs_data   (idex_rs_data),
        .idex_rt_data   (idex_rt_data),
        .idex_imm       (idex_imm),
        .idex_instr     (idex_instr),
        .idex_wr_reg    (idex_wr_reg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid   = 1'b0;
        if_pc      = '0;
        if_instr   = '0;
        ex_regwr   = 1'b0;
        ex_memrd   = 1'b0;
        ex_wr_reg  = '0;
        mem_regwr  = 1'b0;
        mem_memrd  = 1'b0;
        mem_wr_reg = '0;
        mem_data   = '0;
        wb_regwr   = 1'b0;
        wb_wr_reg  = '0;
        wb_data    = '0;
        irq        = 1'b0;
    endtask

    task automatic drain();
        idle();
        step();
        step();
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        idle();
        wb_regwr  = 1'b1;
        wb_wr_reg = r;
        wb_data   = d;
        step();
        wb_regwr  = 1'b0;
    endtask

    // Presents one instruction to IF for one edge so it lands in IF/ID.
    task automatic load_id(input logic [31:0] pc, input logic [31:0] instr);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
        step();
        if_valid = 1'b0;
        if_pc    = '0;
        if_instr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        #2;
        n_run++; if (id_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_id_ready: got %h want 1", id_ready); end
        n_run++; if (redirect_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_redirect: got %h want 0", redirect_valid); end
        n_run++; if (idex_valid !== 1'b0 || idex_irq !== 1'b0) begin n_fail++;
            $display("FAIL reset_idex_flags: got %h/%h want 0/0", idex_valid, idex_irq); end
        n_run++; if (idex_instr !== 32'h0 || idex_pc !== 32'h0) begin n_fail++;
            $display("FAIL reset_idex_data: got %h/%h want 0/0", idex_instr, idex_pc); end
        n_run++; if (irq_ack !== 1'b0) begin n_fail++;
            $display("FAIL reset_irq_ack: got %h want 0", irq_ack); end
        #5;
        reset = 1'b1;
        step();
    endtask

    task automatic test_write_through();
        drain();
        load_id(32'h10, 32'h0100_4820);             // add r9,r8,r0
        wb_regwr = 1'b1; wb_wr_reg = 5'd8; wb_data = 32'hDEAD;
        step();
        wb_regwr = 1'b0;
        n_run++; if (idex_rs_data !== 32'hDEAD) begin n_fail++;
            $display("FAIL wt_bypass: got %h want 0000dead", idex_rs_data); end
        n_run++; if (idex_valid !== 1'b1 || idex_wr_reg !== 5'd9 || idex_pc !== 32'h10) begin
            n_fail++;
            $display("FAIL wt_slot: got %h/%0d/%h want 1/9/10", idex_valid, idex_wr_reg, idex_pc);
        end
        load_id(32'h14, 32'h0100_4820);
        step();
        n_run++; if (idex_rs_data !== 32'hDEAD) begin n_fail++;
            $display("FAIL wt_stored: got %h want 0000dead", idex_rs_data); end
        load_id(32'h18, 32'h0000_4820);             // add r9,r0,r0 while WB writes r0
        wb_regwr = 1'b1; wb_wr_reg = 5'd0; wb_data = 32'h1234;
        step();
        wb_regwr = 1'b0;
        n_run++; if (idex_rs_data !== 32'h0) begin n_fail++;
            $display("FAIL wt_r0: got %h want 0", idex_rs_data); end
    endtask

    task automatic test_load_use();
        drain();
        wb_write(5'd2, 32'h11);
        wb_write(5'd4, 32'h22);
        load_id(32'h20, 32'h0044_1820);             // add r3,r2,r4
        if_valid = 1'b1; if_pc = 32'h24; if_instr = 32'h0;
        ex_memrd = 1'b1; ex_regwr = 1'b1; ex_wr_reg = 5'd2;
        #1;
        n_run++; if (id_ready !== 1'b0) begin n_fail++;
            $display("FAIL lu_stall: got id_ready=%h want 0", id_ready); end
        step();
        n_run++; if (idex_valid !== 1'b0 || idex_instr !== 32'h0) begin n_fail++;
            $display("FAIL lu_bubble: got %h/%h want 0/0", idex_valid, idex_instr); end
        ex_memrd = 1'b0; ex_regwr = 1'b0; ex_wr_reg = '0;
        mem_memrd = 1'b1; mem_regwr = 1'b1; mem_wr_reg = 5'd2;
        #1;
        n_run++; if (id_ready !== 1'b1) begin n_fail++;
            $display("FAIL lu_release: got id_ready=%h want 1", id_ready); end
        step();
        n_run++; if (idex_valid !== 1'b1 || idex_instr !== 32'h0044_1820) begin n_fail++;
            $display("FAIL lu_issue: got %h/%h want 1/00441820", idex_valid, idex_instr); end
        n_run++; if (idex_rs_data !== 32'h11 || idex_rt_data !== 32'h22 || idex_wr_reg !== 5'd3)
        begin
            n_fail++;
            $display("FAIL lu_operands: got %h/%h/%0d want 11/22/3",
                     idex_rs_data, idex_rt_data, idex_wr_reg);
        end
        idle();
        step();
        n_run++; if (idex_valid !== 1'b1 || idex_pc !== 32'h24) begin n_fail++;
            $display("FAIL lu_held_if: got %h/%h want 1/24", idex_valid, idex_pc); end
    endtask

    task automatic test_branch();
        drain();
        wb_write(5'd1, 32'd5);
        load_id(32'h100, 32'h1021_0003);            // beq r1,r1,+3
        if_valid = 1'b1; if_pc = 32'h104; if_instr = 32'h0000_4820;
        #1;
        n_run++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h110) begin n_fail++;
            $display("FAIL beq_redirect: got %h/%h want 1/110", redirect_valid, redirect_pc); end
        step();
        n_run++; if (idex_valid !== 1'b1 || idex_pc !== 32'h100 || idex_instr !== 32'h1021_0003)
        begin
            n_fail++;
            $display("FAIL beq_proceeds: got %h/%h/%h want 1/100/10210003",
                     idex_valid, idex_pc, idex_instr);
        end
        if_valid = 1'b0;
        #1;
        n_run++; if (redirect_valid !== 1'b0) begin n_fail++;
            $display("FAIL beq_ifid_bubble_redirect: got %h want 0", redirect_valid); end
        step();
        n_run++; if (idex_valid !== 1'b0) begin n_fail++;
            $display("FAIL beq_flush: got idex_valid=%h want 0", idex_valid); end
        load_id(32'h120, 32'h1421_0003);            // bne r1,r1: not taken
        #1;
        n_run++; if (redirect_valid !== 1'b0) begin n_fail++;
            $display("FAIL bne_not_taken: got %h want 0", redirect_valid); end
        step();
        load_id(32'h140, 32'h1C20_FFFF);            // bgtz r1,-1
        #1;
        n_run++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h140) begin n_fail++;
            $display("FAIL bgtz_back: got %h/%h want 1/140", redirect_valid, redirect_pc); end
        step();
        load_id(32'h4000_0100, 32'h0C00_0123);      // jal
        #1;
        n_run++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4000_048C) begin n_fail++;
            $display("FAIL jal_target: got %h/%h want 1/4000048c", redirect_valid, redirect_pc);
        end
        step();
        n_run++; if (idex_wr_reg !== 5'd31) begin n_fail++;
            $display("FAIL jal_link: got %0d want 31", idex_wr_reg); end
        load_id(32'h130, 32'h0020_0008);            // jr r1
        #1;
        n_run++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'd5) begin n_fail++;
            $display("FAIL jr_target: got %h/%h want 1/5", redirect_valid, redirect_pc); end
        step();
    endtask

    task automatic test_mem_forward();
        drain();
        load_id(32'h200, 32'h14A0_0004);            // bne r5,r0,+4
        mem_regwr = 1'b1; mem_wr_reg = 5'd5; mem_data = 32'd7;
        #1;
        n_run++; if (id_ready !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h214)
        begin
            n_fail++;
            $display("FAIL fwd_bne: got %h/%h/%h want 1/1/214", id_ready, redirect_valid, redirect_pc);
        end
        step();
        idle();
        load_id(32'h300, 32'h14A0_0004);
        ex_regwr = 1'b1; ex_wr_reg = 5'd5;
        #1;
        n_run++; if (id_ready !== 1'b0 || redirect_valid !== 1'b0) begin n_fail++;
            $display("FAIL ex_dep_stall: got %h/%h want 0/0", id_ready, redirect_valid); end
        step();
        n_run++; if (idex_valid !== 1'b0) begin n_fail++;
            $display("FAIL ex_dep_bubble: got %h want 0", idex_valid); end
        ex_regwr = 1'b0; ex_wr_reg = '0;
        mem_regwr = 1'b1; mem_wr_reg = 5'd5; mem_data = 32'd7;
        #1;
        n_run++; if (id_ready !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h314)
        begin
            n_fail++;
            $display("FAIL ex_dep_resolve: got %h/%h/%h want 1/1/314",
                     id_ready, redirect_valid, redirect_pc);
        end
        step();
        n_run++; if (idex_valid !== 1'b1 || idex_pc !== 32'h300) begin n_fail++;
            $display("FAIL ex_dep_issue: got %h/%h want 1/300", idex_valid, idex_pc); end
        idle();
        load_id(32'h400, 32'h14A0_0004);
        mem_memrd = 1'b1; mem_regwr = 1'b1; mem_wr_reg = 5'd5;
        #1;
        n_run++; if (id_ready !== 1'b0) begin n_fail++;
            $display("FAIL mem_load_branch_stall: got %h want 0", id_ready); end
        idle();
        step();
    endtask

    task automatic test_irq();
        drain();
        if_valid = 1'b1; if_pc = 32'h40; if_instr = 32'h0100_4820;
        irq = 1'b1;
        step();
        if_valid = 1'b0; irq = 1'b0;
        #1;
        n_run++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0004 || irq_ack !== 1'b0)
        begin
            n_fail++;
            $display("FAIL irq_redirect: got %h/%h/%h want 1/80000004/0",
                     redirect_valid, redirect_pc, irq_ack);
        end
        step();
        n_run++; if (irq_ack !== 1'b1 || idex_irq !== 1'b1 || idex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_entry: got %h/%h/%h want 1/1/1", irq_ack, idex_irq, idex_valid);
        end
        n_run++; if (idex_pc !== 32'h40 || idex_wr_reg !== 5'd26) begin n_fail++;
            $display("FAIL irq_link: got %h/%0d want 40/26", idex_pc, idex_wr_reg); end
        step();
        n_run++; if (irq_ack !== 1'b0 || idex_irq !== 1'b0 || idex_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_after: got %h/%h/%h want 0/0/0", irq_ack, idex_irq, idex_valid);
        end
        // Kernel PC: request must stay pending.
        if_valid = 1'b1; if_pc = 32'h8000_0040; if_instr = 32'h0100_4820;
        irq = 1'b1;
        step();
        if_valid = 1'b0; irq = 1'b0;
        #1;
        n_run++; if (redirect_valid !== 1'b0) begin n_fail++;
            $display("FAIL irq_kernel_redirect: got %h want 0", redirect_valid); end
        step();
        n_run++; if (irq_ack !== 1'b0 || idex_irq !== 1'b0 || idex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_kernel_slot: got %h/%h/%h want 0/0/1", irq_ack, idex_irq, idex_valid);
        end
        load_id(32'h50, 32'h0100_4820);
        #1;
        n_run++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0004) begin n_fail++;
            $display("FAIL irq_pending_held: got %h/%h want 1/80000004", redirect_valid, redirect_pc);
        end
        step();
        n_run++; if (irq_ack !== 1'b1 || idex_pc !== 32'h50) begin n_fail++;
            $display("FAIL irq_late_ack: got %h/%h want 1/50", irq_ack, idex_pc); end
        step();
    endtask

    task automatic test_reset_mid_stall();
        drain();
        load_id(32'h60, 32'h0044_1820);
        if_valid = 1'b1; if_pc = 32'h64; if_instr = 32'h0044_1820;
        ex_memrd = 1'b1; ex_regwr = 1'b1; ex_wr_reg = 5'd6;
        step();
        if_valid = 1'b0;
        ex_wr_reg = 5'd2;
        #1;
        n_run++; if (id_ready !== 1'b0 || idex_valid !== 1'b1) begin n_fail++;
            $display("FAIL rst_pre_stall: got %h/%h want 0/1", id_ready, idex_valid); end
        #1;
        reset = 1'b0;
        #1;
        n_run++; if (id_ready !== 1'b1 || redirect_valid !== 1'b0 || irq_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_ctrl: got %h/%h/%h want 1/0/0", id_ready, redirect_valid, irq_ack);
        end
        n_run++; if (idex_valid !== 1'b0 || idex_pc !== 32'h0 || idex_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_async_idex: got %h/%h/%h want 0/0/0", idex_valid, idex_pc, idex_instr);
        end
        #1;
        reset = 1'b1;
        idle();
        load_id(32'h70, 32'h0044_1820);
        step();
        n_run++; if (idex_valid !== 1'b1 || idex_rs_data !== 32'h0 || idex_rt_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_rf_cleared: got %h/%h/%h want 1/0/0",
                     idex_valid, idex_rs_data, idex_rt_data);
        end
    endtask

    initial begin
        test_reset();
        test_write_through();
        test_load_use();
        test_branch();
        test_mem_forward();
        test_irq();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule
